term_sched: RTL and testbench

Round-robin scheduler and sequencer that shares one series-term datapath (the x register / term register / 3-bit term counter unit) among NREQ function requesters (sin, cos, ln, exp evaluators). It grants one requester at a time, drives the datapath control strobes to generate terms 0..7 for that requester's operand, and returns each term tagged with requester id and term index. It sits between the function-level controllers and the single shared term datapath.

---
 rtl/term_sched_pkg.sv | 19 +
 rtl/term_sched_if.sv | 30 +++
 rtl/term_sched_rr_arbiter.sv | 32 +++
 rtl/term_sched.sv | 131 +++++++++++++
 tb/tb_term_sched.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/term_sched_pkg.sv
// term_sched_pkg: shared constants, FSM encodings and helpers
// for the series-term scheduler and its round-robin arbiter.
package term_sched_pkg;

  localparam int TERMS = 8;
  localparam int CNT_W = 3;
  localparam int W_DEF = 16;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_EMIT = 3'd2;
  localparam logic [2:0] S_STEP = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/term_sched_if.sv
// term_sched_if: control/data bus between the scheduler (master)
// and the shared series-term datapath (slave).
interface term_sched_if
  import term_sched_pkg::*;
#(
  parameter int W = W_DEF
);
  logic [W-1:0]     xbus;
  logic             ldx;
  logic             init_t;
  logic             init_counter;
  logic             ldt;
  logic             counter_en;
  logic             select;
  logic [W-1:0]     tbus;
  logic             co;
  logic [CNT_W-1:0] count;

  modport master (
    output xbus, ldx, init_t, init_counter,
    output ldt, counter_en, select,
    input  tbus, co, count
  );

  modport slave (
    input  xbus, ldx, init_t, init_counter,
    input  ldt, counter_en, select,
    output tbus, co, count
  );
endinterface

// File: rtl/term_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; search starts
// at ptr+1 and wraps, so ptr itself has lowest priority.
module rr_arbiter
  import term_sched_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDW = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  id,
  output logic            any
);
  logic [IDW-1:0] idx;

  // first requester found after ptr wins
  always_comb begin
    gnt = '0;
    id  = '0;
    any = 1'b0;
    idx = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IDW'((int'(ptr) + i) % NREQ);
      if (!any && req[idx]) begin
        any      = 1'b1;
        id       = idx;
        gnt[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/term_sched.sv
// term_sched: round-robin sequencer sharing one series-term datapath.
// Optional TERM_SCHED_STALL_EN adds term_ready backpressure on terms.
module term_sched
  import term_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W = W_DEF,
  localparam int IDW = id_w(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_x,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic [W-1:0]      term,
  output logic              term_valid,
  output logic [CNT_W-1:0]  term_idx,
  output logic [IDW-1:0]    term_id,
  output logic              job_done,
`ifdef TERM_SCHED_STALL_EN
  input  logic              term_ready,
`endif
  term_sched_if.master      dp
);
  logic [2:0]       state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IDW-1:0]   own_q, own_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [W-1:0]     term_q, term_d;
  logic             tv_q, tv_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [IDW-1:0]   tid_q, tid_d;
  logic [NREQ-1:0]  arb_gnt;
  logic [IDW-1:0]   arb_id;
  logic             arb_any;
  logic             stall;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .id  (arb_id),
    .any (arb_any)
  );

`ifdef TERM_SCHED_STALL_EN
  assign stall = tv_q & ~term_ready;
`else
  assign stall = 1'b0;
`endif

  // next-state, grant and term capture
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    term_d  = term_q;
    idx_d   = idx_q;
    tid_d   = tid_q;
    tv_d    = stall;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (arb_any) begin
          gnt_d   = arb_gnt;
          own_d   = arb_id;
          state_d = S_LOAD;
        end
      end
      (state_q == S_LOAD): state_d = S_EMIT;
      (state_q == S_EMIT): begin
        if (!stall) begin
          term_d  = dp.tbus;
          idx_d   = dp.count;
          tid_d   = own_q;
          tv_d    = 1'b1;
          state_d = dp.co ? S_DONE : S_STEP;
        end
      end
      (state_q == S_STEP): state_d = S_EMIT;
      (state_q == S_DONE): begin
        if (!stall) begin
          gnt_d   = '0;
          ptr_d   = own_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      own_q   <= '0;
      ptr_q   <= IDW'(NREQ - 1);
      term_q  <= '0;
      tv_q    <= 1'b0;
      idx_q   <= '0;
      tid_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      term_q  <= term_d;
      tv_q    <= tv_d;
      idx_q   <= idx_d;
      tid_q   <= tid_d;
    end
  end

  assign gnt        = gnt_q;
  assign busy       = (state_q != S_IDLE);
  assign term       = term_q;
  assign term_valid = tv_q;
  assign term_idx   = idx_q;
  assign term_id    = tid_q;
  assign job_done   = (state_q == S_DONE) & ~stall;

  assign dp.xbus         = busy ? req_x[int'(own_q)*W +: W] : '0;
  assign dp.ldx          = (state_q == S_LOAD);
  assign dp.init_t       = (state_q == S_LOAD);
  assign dp.init_counter = (state_q == S_LOAD);
  assign dp.ldt          = (state_q == S_STEP);
  assign dp.counter_en   = (state_q == S_STEP);
  assign dp.select       = (state_q == S_STEP);
endmodule

// File: tb/tb_term_sched.sv
// tb_term_sched: directed bench for term_sched with a simple
// term datapath model (term k = x + k).
module tb_term_sched;
  localparam int NREQ = 4;
  localparam int W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic [W-1:0]      term;
  logic              term_valid;
  logic [2:0]        term_idx;
  logic [1:0]        term_id;
  logic              job_done;
  logic [W-1:0]      t_q;
  logic [2:0]        c_q;
  logic [W-1:0]      xv [NREQ];
  int                n_run = 0;
  int                n_fail = 0;

  term_sched_if #(.W(W)) dp ();

  term_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_x      (req_x),
    .gnt        (gnt),
    .busy       (busy),
    .term       (term),
    .term_valid (term_valid),
    .term_idx   (term_idx),
    .term_id    (term_id),
    .job_done   (job_done),
`ifdef TERM_SCHED_STALL_EN
    .term_ready (1'b1),
`endif
    .dp         (dp)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dp.init_t) t_q <= dp.xbus;
    else if (dp.ldt) t_q <= t_q + 16'd1;
    if (dp.init_counter) c_q <= 3'd0;
    else if (dp.counter_en) c_q <= c_q + 3'd1;
  end

  assign dp.tbus  = t_q;
  assign dp.co    = (c_q == 3'd7);
  assign dp.count = c_q;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input logic [NREQ-1:0] r);
    @(negedge clk);
    rst = 1'b1;
    req = r;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic job(input int eid, input int ew, input int drop_k);
    int w = 0;
    int n = 0;
    int nv = 0;
    int nl = 0;
    int nx = 0;
    int bad = 0;
    int jd = -1;
    while (!busy && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (ew >= 0) check("grant_wait", w, ew);
    else check("grant_bound", 32'(w < 40), 1);
    check("gnt", 32'(gnt), 32'(1 << eid));
    while (busy && n < 40) begin
      if (n == 0) begin
        if (!(dp.ldx && dp.init_t && dp.init_counter)) bad++;
      end else if (dp.ldx || dp.init_t || dp.init_counter) bad++;
      if (dp.ldt) nl++;
      if (dp.select !== dp.ldt || dp.counter_en !== dp.ldt) bad++;
      if (dp.xbus !== xv[eid] || gnt !== NREQ'(1 << eid)) nx++;
      if (term_valid) begin
        check("tv_cycle", n, 2 + 2 * nv);
        check("term_idx", 32'(term_idx), nv);
        check("term", 32'(term), 32'(xv[eid]) + nv);
        check("term_id", 32'(term_id), eid);
        if (drop_k >= 0 && nv == drop_k) req[eid] = 1'b0;
        nv++;
      end
      if (job_done) jd = n;
      n++;
      @(negedge clk);
    end
    check("busy_cycles", n, 17);
    check("ldt_pulses", nl, 7);
    check("terms", nv, 8);
    check("job_done_cyc", jd, 16);
    check("strobes", bad, 0);
    check("xbus_gnt", nx, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    int jd;
    xv[0] = 16'h0100;
    xv[1] = 16'h2000;
    xv[2] = 16'h3000;
    xv[3] = 16'h4000;
    req_x = {xv[3], xv[2], xv[1], xv[0]};

    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_term", 32'(term), 0);
    check("rst_tv", 32'(term_valid), 0);
    check("rst_idx", 32'(term_idx), 0);
    check("rst_id", 32'(term_id), 0);
    check("rst_done", 32'(job_done), 0);
    check("rst_xbus", 32'(dp.xbus), 0);
    check("rst_strb", 32'({dp.ldx, dp.init_t, dp.init_counter,
                          dp.ldt, dp.counter_en, dp.select}), 0);

    rst = 1'b0;
    @(negedge clk);
    req = 4'b0001;
    job(0, 1, -1);
    req = '0;
    repeat (3) @(negedge clk);
    check("idle_after", 32'(busy), 0);

    do_reset(4'b1111);
    job(0, 1, -1);
    job(1, 1, -1);
    job(2, 1, -1);
    job(3, 1, -1);
    job(0, 1, -1);
    req = '0;

    do_reset(4'b0100);
    job(2, 1, 3);
    check("drop_req", 32'(req), 0);
    repeat (3) @(negedge clk);
    check("drop_idle", 32'(gnt), 0);

    do_reset(4'b0001);
    jd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (job_done) jd++;
    end
    check("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check("mid_busy", 32'(busy), 0);
    check("mid_gnt", 32'(gnt), 0);
    check("mid_tv", 32'(term_valid), 0);
    check("mid_term", 32'(term), 0);
    check("mid_done", 32'(job_done), 0);
    check("mid_xbus", 32'(dp.xbus), 0);
    check("mid_ldt", 32'(dp.ldt), 0);
    check("no_done", jd, 0);
    @(negedge clk);
    req = 4'b0010;
    rst = 1'b0;
    @(negedge clk);
    check("post_gnt", 32'(gnt), 32'h2);
    req = 4'b0011;
    job(1, 0, -1);
    job(0, 1, -1);
    job(1, 1, -1);
    req = '0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
